gsx_master_ctl: RTL
===================

Name: gsx_master_ctl

Overview:
Parametrised SGPIO (SFF-8485 style) serial expander master. It shifts a NUM_BITS output vector to external shift-register chains and captures the returning serial input vector. SClock is generated with a clock-enable counter, so all logic runs on the single system clock with no derived clocks. Supports single-shot and continuous framing, frame-consistent snapshots, a frame-done strobe and an optional input debounce. Sits between CPLD status/LED logic and the board SGPIO header.

Parameters:
NUM_BITS, 24, bits per frame; legal range 2..256.
CLK_DIV, 10, iClk cycles per SClock half-period; legal range 4..1023. Default gives 100 kHz from 2 MHz.
CNT_W, 16, width of the frame counter.

Ports:
iClk  in  1  system clock (2 MHz nominal)
iReset  in  1  asynchronous active-low reset
iEnable  in  1  master enable; level
iStart  in  1  single-frame request; one-cycle pulse
iContinuous  in  1  1 = back-to-back frames while iEnable=1
ivDataOut  in  NUM_BITS  transmit vector; bit 0 is sent first
oSClock  out  1  SGPIO clock; idles high
oSLoad  out  1  frame marker; idles high
oSDataOut  out  1  serial data out; idles high
iSDataIn  in  1  serial data in; asynchronous to iClk
ovDataIn  out  NUM_BITS  last complete received frame
oFrameDone  out  1  one-cycle strobe when ovDataIn updates
oBusy  out  1  frame in progress
ovFrameCount  out  CNT_W  completed-frame counter

Behaviour:
- Reset (asynchronous, iReset=0), all registers:
  - oSClock=1, oSLoad=1, oSDataOut=1
  - ovDataIn=0, oFrameDone=0, oBusy=0, ovFrameCount=0
  - state=IDLE
- iSDataIn passes through a 2-flop synchroniser (reset value 1) before use.
- FSM states: IDLE, LOW, HIGH. Half-period counter hc is loaded with CLK_DIV-1 on entry to LOW or HIGH and decrements each cycle.
- IDLE:
  - Frame start condition: iEnable=1 and (iStart=1 or iContinuous=1).
  - On the start condition: snapshot ivDataOut into txbuf, set bit index bi=0, go to LOW, oBusy=1.
  - iStart while not in IDLE is ignored; no queuing.
- LOW:
  - Registered outputs on entry: oSClock=0, oSDataOut=txbuf[bi], oSLoad=(bi==NUM_BITS-1).
  - Go to HIGH when hc==0.
- HIGH:
  - oSClock=1; oSDataOut and oSLoad are held.
  - On the last cycle (hc==0), sample the synchronised input: rxbuf[bi] <= sync_in.
  - If bi<NUM_BITS-1: bi++, go to LOW.
  - If bi==NUM_BITS-1, the frame ends:
    - ovDataIn <= rxbuf (including the bit just sampled).
    - oFrameDone=1 for exactly one cycle.
    - ovFrameCount++, wrapping modulo 2^CNT_W.
    - If iEnable=1 and iContinuous=1: re-snapshot ivDataOut and go straight to LOW. There is no idle gap and oBusy stays 1.
    - Otherwise: go to IDLE, oBusy=0, oSLoad=1, oSDataOut=1.
- Timing:
  - Frame length is exactly 2*CLK_DIV*NUM_BITS iClk cycles.
  - oSClock first falls 1 cycle after the start condition.
  - oFrameDone is asserted the cycle after the final HIGH phase ends.
- ivDataOut changes mid-frame do not affect the current frame.
- iEnable deasserted mid-frame: the current frame completes normally, then the block idles. iContinuous is evaluated only at frame end.
- Reset asserted mid-frame: the frame is aborted immediately, all outputs go to reset values, and no oFrameDone is issued.
- bi width is clog2(NUM_BITS). CNT_W wrap: all-ones +1 -> 0.

Optional Feature:
GSX_INPUT_DEBOUNCE_EN
- Defined: a per-bit previous-frame register prevbuf (reset 0) is kept. At frame end, ovDataIn[k] updates only when rxbuf[k]==prevbuf[k]; prevbuf<=rxbuf. A changed input appears in ovDataIn after the second consecutive matching frame. oFrameDone and ovFrameCount are unchanged.
- Not defined: ovDataIn<=rxbuf every frame; no prevbuf registers exist.

Test Plan:
1. NUM_BITS=24, CLK_DIV=4; release reset with iEnable=0 -> oSClock/oSLoad/oSDataOut stay 1, oBusy=0, ovDataIn=0 for 500 cycles.
2. iStart pulse with ivDataOut=24'hA5_3C_0F, iSDataIn looped to oSDataOut -> 24 oSClock pulses of 8 cycles each. oSLoad=1 only during bit 23. oFrameDone at cycle 193 after iStart. ovDataIn=24'hA5_3C_0F. ovFrameCount=1. Then idle.
3. iContinuous=1, iEnable=1 for 3 frames, then iEnable=0 in the middle of frame 4 -> oFrameDone pulses exactly every 192 cycles, oBusy stays continuously high, frame 4 completes, ovFrameCount=4, then idle.
4. Change ivDataOut from 24'h000000 to 24'hFFFFFF at bit 10 of a frame -> that frame transmits all zeros; the next frame transmits all ones.
5. Assert iReset during bit 12 -> outputs go to reset values on the same cycle (asynchronous), no oFrameDone. After release and iStart, a full correct frame follows.
6. With GSX_INPUT_DEBOUNCE_EN, iSDataIn bit 5 toggles for one frame only -> ovDataIn[5] never changes. Held for two consecutive frames -> ovDataIn[5] updates at the second oFrameDone. Without the macro -> it updates at the first oFrameDone.

Source files
------------

// File: rtl/gsx_master_ctl.sv
// gsx_master_ctl: SGPIO (SFF-8485 style) serial expander master; SClock is a clock-enable derived waveform on iClk.
// Optional GSX_INPUT_DEBOUNCE_EN: a received bit reaches ovDataIn only after matching on two consecutive frames.
module gsx_master_ctl #(
  parameter int NUM_BITS = 24,
  parameter int CLK_DIV  = 10,
  parameter int CNT_W    = 16
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic                iStart,
  input  logic                iContinuous,
  input  logic [NUM_BITS-1:0] ivDataOut,
  output logic                oSClock,
  output logic                oSLoad,
  output logic                oSDataOut,
  input  logic                iSDataIn,
  output logic [NUM_BITS-1:0] ovDataIn,
  output logic                oFrameDone,
  output logic                oBusy,
  output logic [CNT_W-1:0]    ovFrameCount
);

  localparam int BI_W = $clog2(NUM_BITS);
  localparam int HC_W = $clog2(CLK_DIV);
  localparam logic [BI_W-1:0] LAST_BIT = BI_W'(NUM_BITS - 1);
  localparam logic [HC_W-1:0] HC_LOAD  = HC_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} stateT;

  stateT               stateReg, stateNext;
  logic [HC_W-1:0]     hcReg, hcNext;
  logic [BI_W-1:0]     biReg, biNext, biInc;
  logic [NUM_BITS-1:0] txBufReg, txBufNext;
  logic [NUM_BITS-1:0] rxBufReg, rxBufNext, rxMerged;
  logic [NUM_BITS-1:0] dataInReg, dataInNext, frameDataIn;
  logic                sClockReg, sClockNext;
  logic                sLoadReg, sLoadNext;
  logic                sDataReg, sDataNext;
  logic                frameDoneReg, frameDoneNext;
  logic                busyReg, busyNext;
  logic [CNT_W-1:0]    frameCountReg, frameCountNext;
  logic                syncMeta, syncIn;
  logic                frameEnd;

  // iSDataIn is asynchronous to iClk; idle level of the line is high.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      syncMeta <= 1'b1;
      syncIn   <= 1'b1;
    end else begin
      syncMeta <= iSDataIn;
      syncIn   <= syncMeta;
    end
  end

  assign biInc    = biReg + BI_W'(1);
  assign frameEnd = (stateReg == HIGH) && (hcReg == '0) && (biReg == LAST_BIT);

  // Receive buffer including the bit being sampled this cycle.
  always_comb begin
    rxMerged        = rxBufReg;
    rxMerged[biReg] = syncIn;
  end

`ifdef GSX_INPUT_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prevBufReg;

  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : gDebounce
    assign frameDataIn[gi] = (rxMerged[gi] == prevBufReg[gi]) ? rxMerged[gi] : dataInReg[gi];
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      prevBufReg <= '0;
    end else if (frameEnd) begin
      prevBufReg <= rxMerged;
    end
  end
`else
  assign frameDataIn = rxMerged;
`endif

  always_comb begin
    stateNext      = stateReg;
    hcNext         = hcReg;
    biNext         = biReg;
    txBufNext      = txBufReg;
    rxBufNext      = rxBufReg;
    dataInNext     = dataInReg;
    sClockNext     = sClockReg;
    sLoadNext      = sLoadReg;
    sDataNext      = sDataReg;
    frameDoneNext  = 1'b0;
    busyNext       = busyReg;
    frameCountNext = frameCountReg;

    case (stateReg)
      IDLE: begin
        if (iEnable && (iStart || iContinuous)) begin
          txBufNext  = ivDataOut;
          biNext     = '0;
          hcNext     = HC_LOAD;
          stateNext  = LOW;
          sClockNext = 1'b0;
          sDataNext  = ivDataOut[0];
          sLoadNext  = 1'b0;
          busyNext   = 1'b1;
        end
      end

      LOW: begin
        if (hcReg == '0) begin
          stateNext  = HIGH;
          hcNext     = HC_LOAD;
          sClockNext = 1'b1;
        end else begin
          hcNext = hcReg - HC_W'(1);
        end
      end

      HIGH: begin
        if (hcReg != '0) begin
          hcNext = hcReg - HC_W'(1);
        end else begin
          rxBufNext = rxMerged;
          if (biReg != LAST_BIT) begin
            biNext     = biInc;
            stateNext  = LOW;
            hcNext     = HC_LOAD;
            sClockNext = 1'b0;
            sDataNext  = txBufReg[biInc];
            sLoadNext  = (biInc == LAST_BIT);
          end else begin
            dataInNext     = frameDataIn;
            frameDoneNext  = 1'b1;
            frameCountNext = frameCountReg + CNT_W'(1);
            // Continuous mode chains straight into bit 0 of the next frame.
            if (iEnable && iContinuous) begin
              txBufNext  = ivDataOut;
              biNext     = '0;
              stateNext  = LOW;
              hcNext     = HC_LOAD;
              sClockNext = 1'b0;
              sDataNext  = ivDataOut[0];
              sLoadNext  = 1'b0;
            end else begin
              stateNext = IDLE;
              busyNext  = 1'b0;
              sLoadNext = 1'b1;
              sDataNext = 1'b1;
            end
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      stateReg      <= IDLE;
      hcReg         <= '0;
      biReg         <= '0;
      txBufReg      <= '0;
      rxBufReg      <= '0;
      dataInReg     <= '0;
      sClockReg     <= 1'b1;
      sLoadReg      <= 1'b1;
      sDataReg      <= 1'b1;
      frameDoneReg  <= 1'b0;
      busyReg       <= 1'b0;
      frameCountReg <= '0;
    end else begin
      stateReg      <= stateNext;
      hcReg         <= hcNext;
      biReg         <= biNext;
      txBufReg      <= txBufNext;
      rxBufReg      <= rxBufNext;
      dataInReg     <= dataInNext;
      sClockReg     <= sClockNext;
      sLoadReg      <= sLoadNext;
      sDataReg      <= sDataNext;
      frameDoneReg  <= frameDoneNext;
      busyReg       <= busyNext;
      frameCountReg <= frameCountNext;
    end
  end

  assign oSClock      = sClockReg;
  assign oSLoad       = sLoadReg;
  assign oSDataOut    = sDataReg;
  assign ovDataIn     = dataInReg;
  assign oFrameDone   = frameDoneReg;
  assign oBusy        = busyReg;
  assign ovFrameCount = frameCountReg;

endmodule
